// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle of the seven-segment scanner: frame inputs from the
// host and the scanned anode/nibble/dp outputs toward the display.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [3:0]              nibble;
  logic                    dp;
  logic [IW-1:0]           digit_idx;
  logic                    frame_start;

  modport master (
    output value, dp_in, digit_en, brightness,
    input  an, nibble, dp, digit_idx, frame_start
  );

  modport slave (
    input  value, dp_in, digit_en, brightness,
    output an, nibble, dp, digit_idx, frame_start
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with frame snapshots, PWM
// brightness and anti-ghost dead time. Optional: LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int GHOST_CYC  = 16,
  parameter int BRIGHT_W   = 4
) (
  input logic               clk,
  input logic               rst_n,
  seven_seg_scanner_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int OW = $clog2(DIV) + BRIGHT_W + 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GHOST   = CW'(GHOST_CYC);
  localparam logic [OW-1:0] ON_SPAN = OW'(DIV - GHOST_CYC);

  // Full-width product before the shift so low brightness settings keep precision.
  function automatic logic [OW-1:0] calc_on_len(input logic [BRIGHT_W-1:0] b);
    logic [OW-1:0] prod;
    prod = ON_SPAN * ({{(OW-BRIGHT_W){1'b0}}, b} + OW'(1));
    prod = prod >> BRIGHT_W;
    return (prod == '0) ? OW'(1) : prod;
  endfunction

  function automatic logic slot_lit(input logic en, input logic [CW-1:0] c,
                                    input logic [OW-1:0] len);
    logic [OW-1:0] off;
    off = OW'(c) - OW'(GHOST_CYC);
    return en && (c >= GHOST) && (off < len);
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  snap;
  logic [VW-1:0]         val_sh_q, val_sh_d;
  logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0] en_sh_q, en_sh_d;
  logic [OW-1:0]         on_len_q, on_len_d;
  logic [NUM_DIGITS-1:0] keep;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;
  logic                  lit_d;

`ifdef LEADING_ZERO_BLANK_EN
  logic seen;

  // Scan from the top digit down; everything above the first nonzero nibble goes dark.
  always_comb begin
    seen = 1'b0;
    keep = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (bus.value[4*i +: 4] != 4'h0);
      keep[i] = seen || (i == 0);
    end
  end
`else
  assign keep = '1;
`endif

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    snap  = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
        snap  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    val_sh_d = val_sh_q;
    dp_sh_d  = dp_sh_q;
    en_sh_d  = en_sh_q;
    on_len_d = on_len_q;
    if (snap) begin
      val_sh_d = bus.value;
      dp_sh_d  = bus.dp_in;
      en_sh_d  = bus.digit_en & keep;
      on_len_d = calc_on_len(bus.brightness);
    end
  end

  // Outputs are derived from next-state so they line up with (idx_q, cnt_q) once registered.
  always_comb begin
    lit_d = 1'b0;
    an_d  = '1;
    nib_d = '0;
    dp_d  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        lit_d   = slot_lit(en_sh_d[i], cnt_d, on_len_d);
        an_d[i] = ~lit_d;
        nib_d   = val_sh_d[4*i +: 4];
        dp_d    = dp_sh_d[i] & lit_d;
      end
    end
    fs_d = (idx_d == '0) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      val_sh_q <= '0;
      dp_sh_q  <= '0;
      en_sh_q  <= '0;
      on_len_q <= '0;
      an_q     <= '1;
      nib_q    <= '0;
      dp_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      val_sh_q <= val_sh_d;
      dp_sh_q  <= dp_sh_d;
      en_sh_q  <= en_sh_d;
      on_len_q <= on_len_d;
      an_q     <= an_d;
      nib_q    <= nib_d;
      dp_q     <= dp_d;
      fs_q     <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.nibble      = nib_q;
  assign bus.dp          = dp_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a frame-level model (time index -> slot/count,
// per-frame input snapshot) checked every cycle, plus pinned literal points.
module tb_seven_seg_scanner;
  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int GH    = 2;
  localparam int BW    = 2;
  localparam int FRAME = ND * DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seven_seg_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

  seven_seg_scanner #(.NUM_DIGITS(ND), .DIV(DIV), .GHOST_CYC(GH), .BRIGHT_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Model state: t = cycles since reset release; sv_* = inputs latched for the current frame.
  int          t;
  logic [15:0] sv_val;
  logic [3:0]  sv_dp, sv_en;
  int          sv_on;

  function automatic int on_len_of(input logic [BW-1:0] b);
    int v;
    v = ((DIV - GH) * (int'(b) + 1)) >> BW;
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [3:0] keep_mask(input logic [15:0] v);
    logic [3:0] m;
    int top;
    top = 0;
    for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) top = i;
    for (int i = 0; i < ND; i++) m[i] = (i <= top);
`ifdef LEADING_ZERO_BLANK_EN
    return m;
`else
    return (m | 4'hF);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t      <= 0;
      sv_val <= '0;
      sv_dp  <= '0;
      sv_en  <= '0;
      sv_on  <= 0;
    end else begin
      if (t % FRAME == FRAME - 1) begin
        sv_val <= bus.value;
        sv_dp  <= bus.dp_in;
        sv_en  <= bus.digit_en & keep_mask(bus.value);
        sv_on  <= on_len_of(bus.brightness);
      end
      t <= t + 1;
    end
  end

  logic [3:0] e_an, e_nib;
  logic       e_dp, e_fs, e_lit;
  logic [1:0] e_idx;
  int         m_idx, m_cnt;

  always @(negedge clk) begin
    if (chk_on) begin
      m_idx = (t / DIV) % ND;
      m_cnt = t % DIV;
      e_lit = sv_en[m_idx] && (m_cnt >= GH) && ((m_cnt - GH) < sv_on);
      e_an  = 4'hF;
      if (e_lit) e_an[m_idx] = 1'b0;
      e_nib = sv_val[4*m_idx +: 4];
      e_dp  = sv_dp[m_idx] && e_lit;
      e_idx = 2'(m_idx);
      e_fs  = (t % FRAME == 0) && (t != 0);
      checks++;
      if ({bus.an, bus.nibble, bus.dp, bus.digit_idx, bus.frame_start} !==
          {e_an, e_nib, e_dp, e_idx, e_fs}) begin
        failures++;
        $display("FAIL model t=%0d got an=%b nib=%h dp=%b idx=%0d fs=%b want an=%b nib=%h dp=%b idx=%0d fs=%b",
                 t, bus.an, bus.nibble, bus.dp, bus.digit_idx, bus.frame_start,
                 e_an, e_nib, e_dp, e_idx, e_fs);
      end
      checks++;
      if ($countones(~bus.an) > 1) begin
        failures++;
        $display("FAIL onehot t=%0d got an=%b want at most one low bit", t, bus.an);
      end
    end
  end

  task automatic wait_until(input int target);
    int guard;
    guard = 0;
    while (t < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (t != target) begin
      failures++;
      $display("FAIL wait got t=%0d want t=%0d", t, target);
    end
  endtask

  task automatic chk_lit(input string nm, input logic [3:0] ean, input logic [3:0] enib,
                         input logic edp, input logic efs);
    checks++;
    if ({bus.an, bus.nibble, bus.dp, bus.frame_start} !== {ean, enib, edp, efs}) begin
      failures++;
      $display("FAIL %s got an=%b nib=%h dp=%b fs=%b want an=%b nib=%h dp=%b fs=%b",
               nm, bus.an, bus.nibble, bus.dp, bus.frame_start, ean, enib, edp, efs);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.value      = 16'h1234;
    bus.dp_in      = 4'b0100;
    bus.digit_en   = 4'b1111;
    bus.brightness = 2'd3;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Reset state and the dark first frame.
    wait_until(0);  chk_lit("reset_state", 4'b1111, 4'h0, 1'b0, 1'b0);
    wait_until(4);  chk_lit("first_frame_dark", 4'b1111, 4'h0, 1'b0, 1'b0);

    // Full brightness, digits 4,3,2,1 with dp on digit 2.
    wait_until(32); chk_lit("frame_start_32", 4'b1111, 4'h4, 1'b0, 1'b1);
    wait_until(34); chk_lit("full_d0_lit", 4'b1110, 4'h4, 1'b0, 1'b0);
    wait_until(42); bus.value = 16'hABCD;
    wait_until(51); chk_lit("coherent_d2_dp", 4'b1011, 4'h2, 1'b1, 1'b0);
    wait_until(63); chk_lit("full_d3_last", 4'b0111, 4'h1, 1'b0, 1'b0);
    wait_until(66); chk_lit("new_frame_d0", 4'b1110, 4'hD, 1'b0, 1'b0);
    bus.brightness = 2'd1;
    wait_until(91); chk_lit("new_frame_d3", 4'b0111, 4'hA, 1'b0, 1'b0);

    // Dimming: on_len 3 then 1.
    wait_until(100); chk_lit("dim1_cnt4_lit", 4'b1110, 4'hD, 1'b0, 1'b0);
    wait_until(101); chk_lit("dim1_cnt5_dark", 4'b1111, 4'hD, 1'b0, 1'b0);
    bus.brightness = 2'd0;
    wait_until(130); chk_lit("dim0_cnt2_lit", 4'b1110, 4'hD, 1'b0, 1'b0);
    wait_until(131); chk_lit("dim0_cnt3_dark", 4'b1111, 4'hD, 1'b0, 1'b0);
    bus.brightness = 2'd3;
    bus.digit_en   = 4'b1010;

    // Enable mask: digits 0 and 2 stay dark but nibble is still driven.
    wait_until(163); chk_lit("en_d0_dark", 4'b1111, 4'hD, 1'b0, 1'b0);
    wait_until(171); chk_lit("en_d1_lit", 4'b1101, 4'hC, 1'b0, 1'b0);
    wait_until(179); chk_lit("en_d2_dark", 4'b1111, 4'hB, 1'b0, 1'b0);
    bus.value    = 16'h0050;
    bus.digit_en = 4'b1111;
    bus.dp_in    = 4'b0000;

    // Leading-zero behaviour.
    wait_until(195); chk_lit("lz_0050_d0", 4'b1110, 4'h0, 1'b0, 1'b0);
    wait_until(203); chk_lit("lz_0050_d1", 4'b1101, 4'h5, 1'b0, 1'b0);
    wait_until(211);
`ifdef LEADING_ZERO_BLANK_EN
    chk_lit("lz_0050_d2", 4'b1111, 4'h0, 1'b0, 1'b0);
`else
    chk_lit("lz_0050_d2", 4'b1011, 4'h0, 1'b0, 1'b0);
`endif
    bus.value = 16'h0000;
    wait_until(227); chk_lit("lz_zero_d0", 4'b1110, 4'h0, 1'b0, 1'b0);
    wait_until(235);
`ifdef LEADING_ZERO_BLANK_EN
    chk_lit("lz_zero_d1", 4'b1111, 4'h0, 1'b0, 1'b0);
`else
    chk_lit("lz_zero_d1", 4'b1101, 4'h0, 1'b0, 1'b0);
`endif

    // Mid-slot reset at digit 2, cnt 5.
    wait_until(277);
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({bus.an, bus.nibble, bus.dp, bus.digit_idx, bus.frame_start} !== {4'b1111, 4'h0, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got an=%b nib=%h dp=%b idx=%0d fs=%b want an=1111 nib=0 dp=0 idx=0 fs=0",
               bus.an, bus.nibble, bus.dp, bus.digit_idx, bus.frame_start);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_until(2);  chk_lit("post_reset_dark", 4'b1111, 4'h0, 1'b0, 1'b0);
    wait_until(32); chk_lit("post_reset_fs", 4'b1111, 4'h0, 1'b0, 1'b1);

    // Randomized inputs, changed at arbitrary points of the frame.
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        bus.value      = 16'($urandom >> (4 * $urandom_range(4, 7)));
        if ($urandom_range(0, 2) == 0) bus.value = 16'($urandom);
        bus.dp_in      = 4'($urandom);
        bus.digit_en   = 4'($urandom);
        bus.brightness = 2'($urandom);
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised time-multiplexed driver for common-anode 7-segment banks of NUM_DIGITS digits. It replaces a fixed 4-digit, externally-clocked scanner with four additions: an internal refresh prescaler, frame-coherent input snapshots, per-digit enable and decimal point, and PWM brightness with anti-ghost dead time. The nibble output feeds the existing hex/BCD-to-segment decoder; the an output drives the anode pins directly.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
DIV, 50000, clk cycles per digit slot (>= GHOST_CYC+2)
GHOST_CYC, 16, all-dark cycles at start of each slot (>= 1)
BRIGHT_W, 4, brightness input width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
value  in  4*NUM_DIGITS  nibbles to display; digit i = value[4i+3:4i], digit 0 = rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit
digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit always dark
brightness  in  BRIGHT_W  0 = dimmest, all-ones = full on-window
an  out  NUM_DIGITS  anode enables, active-low
nibble  out  4  nibble of current slot's digit
dp  out  1  decimal point, active-high, asserted only while the digit is lit
digit_idx  out  max(1,clog2(NUM_DIGITS))  current slot index
frame_start  out  1  one-cycle pulse on the first cycle of the digit-0 slot

Behaviour:
- Reset (async assert, sync release): an = all 1s, nibble = 0, dp = 0, digit_idx = 0, frame_start = 0. Slot counter cnt = 0. All shadow registers = 0, so the first frame after reset is dark.
- cnt runs 0..DIV-1 every clk. At DIV-1 it wraps to 0 and digit_idx increments. digit_idx wraps from NUM_DIGITS-1 to 0 (covers non-power-of-2 NUM_DIGITS).
- Snapshot: on the cycle where cnt==DIV-1 and digit_idx==NUM_DIGITS-1, the following are registered into shadows: value, dp_in, digit_en, and on_len = ((DIV-GHOST_CYC)*(brightness+1)) >> BRIGHT_W.
- on_len is computed at full width clog2(DIV)+BRIGHT_W+1, with no truncation before the shift. If the result is 0, it is forced to 1.
- Input changes mid-frame have no visible effect until the next frame_start.
- lit = shadow_en[idx] && cnt >= GHOST_CYC && (cnt-GHOST_CYC) < on_len.
- an[idx] = !lit; all other an bits = 1. At most one an bit is low in any cycle, and all bits are high during dead time.
- nibble = shadow_value[4*idx +: 4] for the whole slot, including dark cycles.
- dp = shadow_dp[idx] && lit.
- Outputs are registers, computed from next-state so that in the cycle where (digit_idx, cnt) = (i, k) they reflect slot i, count k. There is zero-cycle skew between an, nibble and dp.
- frame_start = 1 exactly in the cycles where digit_idx==0 and cnt==0, excluding the first cycle after reset release.
- rst_n low mid-slot forces the reset values immediately. Scanning restarts at digit 0, cnt 0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: at snapshot, compute a blank mask. Digits above the highest nonzero nibble of value are forced dark. Digit 0 is never blanked by this rule (value 0 shows "0"). The mask ANDs with digit_en.
- Undefined: no mask logic; every enabled digit is lit regardless of value.

Test Plan:
All scenarios use NUM_DIGITS=4, DIV=8, GHOST_CYC=2, BRIGHT_W=2.
1. Reset: pulse rst_n low mid-run at digit_idx=2, cnt=5 -> same-cycle an=1111, nibble=0, dp=0, digit_idx=0. After release, first frame all dark; first frame_start 32 cycles after release.
2. Full brightness: value=16'h1234, dp_in=0100, digit_en=1111, brightness=3 -> from second frame, digit slots in order 0..3 show nibble 4,3,2,1. Per slot: cnt 0-1 an=1111; cnt 2-7 lit (an=1110/1101/1011/0111). dp=1 only during digit 2 lit cycles.
3. Dim: brightness=1 -> on_len=3, an bit low only at cnt 2..4. brightness=0 -> on_len=1, low only at cnt 2. Check the one-hot-low invariant every cycle.
4. Snapshot coherence: change value 16'h1234 -> 16'hABCD while digit_idx=1 -> remaining digits of current frame still show 2,1; next frame shows D,C,B,A.
5. Enable mask: digit_en=1010 -> an bits 0 and 2 never low. nibble is still driven 4 and 2 in those slots.
6. LEADING_ZERO_BLANK_EN: with macro, value=16'h0050 -> digits 3,2 dark, digits 1,0 lit (5,0); value=0 -> only digit 0 lit. Without macro, same stimuli light all four digits.
